// File: rtl/upload_flit_fifo.sv
// upload_flit_fifo
//   Message-aware flit FIFO between the upload flit datapath and the ring
//   upload port. Each entry holds a 16-bit flit and its end-of-message mark.
//   By default a message is presented only after its tail flit is stored
//   (store-and-forward). The ring port then drains it with a valid/ack
//   handshake. Free space is reported so that the upload FSM starts only
//   messages that fit.
//
//   Optional feature macro: UPLOAD_FIFO_CUT_THROUGH_EN
//     defined   : flit_valid = (count != 0). Flits may leave before their
//                 tail arrives. msg_cnt is still maintained.
//     undefined : flit_valid = (count != 0) && (msg_cnt != 0).
//
//   Parameters
//     DEPTH    flit entries (power of two)
//     AW       log2(DEPTH), pointer width
//     MSG_MAX  largest message in flits; threshold for room_for_msg
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     flit_in       flit from the upload datapath
//     en_flit_in    write strobe, one flit per cycle
//     tail_in       flit_in is the last flit of its message
//     fifo_full     count == DEPTH
//     room_for_msg  (DEPTH - count) >= MSG_MAX
//     flit_out      head entry data
//     tail_out      head entry end-of-message mark
//     flit_valid    head entry may be taken by the ring port
//     flit_ack      ring port consumes the head entry this cycle
//     msg_cnt       complete messages held
//     count         flits held
//     ovf_err       sticky: a write was attempted while full
module upload_flit_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned MSG_MAX = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   flit_in,
  input  logic          en_flit_in,
  input  logic          tail_in,
  output logic          fifo_full,
  output logic          room_for_msg,
  output logic [15:0]   flit_out,
  output logic          tail_out,
  output logic          flit_valid,
  input  logic          flit_ack,
  output logic [AW:0]   msg_cnt,
  output logic [AW:0]   count,
  output logic          ovf_err
);

  localparam logic [AW:0] LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_MSG_MAX = (AW+1)'(MSG_MAX);

  // Storage entry layout: {tail, flit}
  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_msg_cnt;
  logic          r_ovf_err;

  logic          w_full;
  logic          w_valid;
  logic          w_head_tail;
  logic          w_wr_accept;
  logic          w_rd_accept;
  logic          w_wr_tail;
  logic          w_rd_tail;

  // Status derives from registered state only; the full check uses the
  // current count, so a same-cycle read never makes room for a write.
  assign w_full      = (r_count == LP_DEPTH);
  assign w_head_tail = r_mem[r_rd_ptr][16];

`ifdef UPLOAD_FIFO_CUT_THROUGH_EN
  assign w_valid = (r_count != '0);
`else
  // Only complete messages are released. Because messages are stored in
  // order, a non-zero msg_cnt guarantees that the head message is complete.
  assign w_valid = (r_count != '0) && (r_msg_cnt != '0);
`endif

  assign w_wr_accept = en_flit_in && !w_full;
  assign w_rd_accept = w_valid && flit_ack;
  assign w_wr_tail   = w_wr_accept && tail_in;
  assign w_rd_tail   = w_rd_accept && w_head_tail;

  // Data array: no reset, contents are qualified by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= {tail_in, flit_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_rd_accept) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg_cnt <= '0;
    end else begin
      unique case ({w_wr_tail, w_rd_tail})
        2'b10:   r_msg_cnt <= r_msg_cnt + 1'b1;
        2'b01:   r_msg_cnt <= r_msg_cnt - 1'b1;
        default: r_msg_cnt <= r_msg_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
    end else if (en_flit_in && w_full) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign fifo_full    = w_full;
  assign room_for_msg = ((LP_DEPTH - r_count) >= LP_MSG_MAX);
  assign flit_out     = r_mem[r_rd_ptr][15:0];
  assign tail_out     = w_head_tail;
  assign flit_valid   = w_valid;
  assign msg_cnt      = r_msg_cnt;
  assign count        = r_count;
  assign ovf_err      = r_ovf_err;

endmodule

// File: tb/tb_upload_flit_fifo.sv
module tb_upload_flit_fifo;

`ifdef UPLOAD_FIFO_CUT_THROUGH_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] flit_in;
  logic        en_flit_in;
  logic        tail_in;
  logic        fifo_full;
  logic        room_for_msg;
  logic [15:0] flit_out;
  logic        tail_out;
  logic        flit_valid;
  logic        flit_ack;
  logic [4:0]  msg_cnt;
  logic [4:0]  count;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  upload_flit_fifo #(.DEPTH(16), .AW(4), .MSG_MAX(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_in      (flit_in),
    .en_flit_in   (en_flit_in),
    .tail_in      (tail_in),
    .fifo_full    (fifo_full),
    .room_for_msg (room_for_msg),
    .flit_out     (flit_out),
    .tail_out     (tail_out),
    .flit_valid   (flit_valid),
    .flit_ack     (flit_ack),
    .msg_cnt      (msg_cnt),
    .count        (count),
    .ovf_err      (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs set afterwards are sampled at the next edge
  // and outputs read afterwards reflect state after this edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] d, input logic t, input logic ack);
    en_flit_in = en;
    flit_in    = d;
    tail_in    = t;
    flit_ack   = ack;
  endtask

  initial begin
    logic [15:0] q[$];
    int          m_count;
    int          sent;
    int          rcvd;
    int          cyc;
    logic        en;
    logic        ack;
    logic        wr;
    logic        rd;

    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state
    chk("rst_count", count, 0);
    chk("rst_msg_cnt", msg_cnt, 0);
    chk("rst_valid", flit_valid, 0);
    chk("rst_room", room_for_msg, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", ovf_err, 0);

    // 2: three-flit message; ack held high where it cannot drain early
    drive(1'b1, 16'h4123, 1'b0, !CT);
    tick();
    chk("m3_count1", count, 1);
    chk("m3_valid1", flit_valid, CT);
    drive(1'b1, 16'h00AB, 1'b0, !CT);
    tick();
    chk("m3_valid2", flit_valid, CT);
    drive(1'b1, 16'h00CD, 1'b1, !CT);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("m3_valid_after_tail", flit_valid, 1);
    chk("m3_msg_cnt", msg_cnt, 1);
    chk("m3_count3", count, 3);
    chk("m3_head0", flit_out, 16'h4123);
    chk("m3_tail0", tail_out, 0);
    tick();
    chk("m3_head1", flit_out, 16'h00AB);
    chk("m3_count2", count, 2);
    tick();
    chk("m3_head2", flit_out, 16'h00CD);
    chk("m3_tail2", tail_out, 1);
    chk("m3_msg_cnt_before", msg_cnt, 1);
    tick();
    chk("m3_count_end", count, 0);
    chk("m3_msg_cnt_end", msg_cnt, 0);
    chk("m3_valid_end", flit_valid, 0);

    // 3: partial message, no tail
    drive(1'b1, 16'h1000, 1'b0, 1'b0);
    tick();
    chk("part_valid1", flit_valid, CT);
    drive(1'b1, 16'h1001, 1'b0, 1'b0);
    tick();
    chk("part_valid2", flit_valid, CT);
    chk("part_count", count, 2);
    chk("part_msg_cnt", msg_cnt, 0);

    // 4: fill to DEPTH, tail on the 16th flit
    for (int i = 2; i < 16; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), (i == 15), 1'b0);
      tick();
      if (i == 4) chk("room_at5", room_for_msg, 1);
      if (i == 5) chk("room_at6", room_for_msg, 0);
      if (i == 14) begin
        chk("full_at15", fifo_full, 0);
        chk("valid_at15", flit_valid, CT);
      end
    end
    chk("full_at16", fifo_full, 1);
    chk("count16", count, 16);
    chk("msg_at16", msg_cnt, 1);
    chk("valid_at16", flit_valid, 1);
    chk("ovf_before", ovf_err, 0);
    drive(1'b1, 16'h1FFF, 1'b1, 1'b0);
    tick();
    chk("ovf_set", ovf_err, 1);
    chk("ovf_count", count, 16);
    chk("ovf_msg", msg_cnt, 1);
    chk("ovf_head", flit_out, 16'h1000);

    // 5: full with write+ack: write dropped, read accepted
    drive(1'b1, 16'h2222, 1'b0, 1'b1);
    tick();
    chk("fullwa_count", count, 15);
    chk("fullwa_head", flit_out, 16'h1001);
    chk("fullwa_msg", msg_cnt, 1);
    chk("fullwa_ovf", ovf_err, 1);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (7) tick();
    chk("half_count", count, 8);
    chk("half_head", flit_out, 16'h1008);
    drive(1'b1, 16'h3000, 1'b0, 1'b1);
    tick();
    chk("wa_notail_count", count, 8);
    chk("wa_notail_msg", msg_cnt, 1);
    chk("wa_notail_head", flit_out, 16'h1009);
    drive(1'b1, 16'h3001, 1'b1, 1'b1);
    tick();
    chk("wa_tail_count", count, 8);
    chk("wa_tail_msg", msg_cnt, 2);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (5) tick();
    chk("drain_head", flit_out, 16'h100F);
    chk("drain_tail", tail_out, 1);
    chk("drain_count3", count, 3);
    tick();
    chk("drain_msg1", msg_cnt, 1);
    chk("drain_count2", count, 2);
    chk("drain_head2", flit_out, 16'h3000);
    chk("drain_valid", flit_valid, 1);
    tick();
    tick();
    chk("drain_count0", count, 0);
    chk("drain_msg0", msg_cnt, 0);
    chk("drain_valid0", flit_valid, 0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // 6: wrap with 40 one-flit messages and random ack gaps
    m_count = 0;
    sent = 0;
    rcvd = 0;
    cyc = 0;
    while (rcvd < 40 && cyc < 2000) begin
      chk("wrap_count", count, m_count);
      if (m_count != 0) begin
        chk("wrap_valid", flit_valid, 1);
        chk("wrap_data", flit_out, q[0]);
        chk("wrap_tail", tail_out, 1);
      end else begin
        chk("wrap_valid_empty", flit_valid, 0);
      end
      en  = (sent < 40) && ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) != 0);
      wr  = en && (m_count < 16);
      rd  = ack && (m_count != 0);
      drive(en, 16'h6000 + 16'(sent), 1'b1, ack);
      if (rd) begin
        void'(q.pop_front());
        rcvd++;
        m_count--;
      end
      if (wr) begin
        q.push_back(16'h6000 + 16'(sent));
        sent++;
        m_count++;
      end
      tick();
      cyc++;
    end
    chk("wrap_all_received", rcvd, 40);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset mid-stream discards everything, including a partial message
    drive(1'b1, 16'h7000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h7001, 1'b0, 1'b0);
    tick();
    chk("pre_rst_count", count, 2);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", flit_valid, 0);
    chk("mid_rst_msg", msg_cnt, 0);
    chk("mid_rst_ovf", ovf_err, 0);
    chk("mid_rst_room", room_for_msg, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
